// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of NUM_CH independent programmable clock dividers.
// Each channel toggles clk_o every D+1 enabled cycles (half-period D+1).
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   sync_i         - (only with CLKDIV_SYNC_EN) restart all channels in phase
//   en_i[i]        - channel run enable; low holds cnt/clk_o/tick_o at 0
//   load_i[i]      - capture div_i slice i as a pending divisor
//   div_i          - packed divisors, channel i at [i*WIDTH +: WIDTH]
//   clk_o[i]       - registered divided clock
//   tick_o[i]      - one-cycle strobe aligned with the rising clk_o[i]
//   pend_o[i]      - a loaded divisor is waiting for the next toggle/restart
// Optional feature macro: CLKDIV_SYNC_EN (adds sync_i).
module clk_div_bank #(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 26,
    parameter int DEFAULT_DIV = 1
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef CLKDIV_SYNC_EN
    input  logic                    sync_i,
`endif
    input  logic [NUM_CH-1:0]       en_i,
    input  logic [NUM_CH-1:0]       load_i,
    input  logic [NUM_CH*WIDTH-1:0] div_i,
    output logic [NUM_CH-1:0]       clk_o,
    output logic [NUM_CH-1:0]       tick_o,
    output logic [NUM_CH-1:0]       pend_o
);

    localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);

    logic sync;
`ifdef CLKDIV_SYNC_EN
    assign sync = sync_i;
`else
    assign sync = 1'b0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0] div_q, div_d;
        logic [WIDTH-1:0] pdiv_q, pdiv_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic             pend_q, pend_d;
        logic             restart;
        logic             hit;

        // A disabled channel behaves like a continuous restart.
        assign restart = sync | ~en_i[i];
        // cnt never passes div_q, so the full WIDTH range is usable.
        assign hit     = (cnt_q == div_q);

        always_comb begin
            div_d  = div_q;
            pdiv_d = pdiv_q;
            pend_d = pend_q;
            cnt_d  = cnt_q;
            clk_d  = clk_q;
            tick_d = 1'b0;

            if (restart) begin
                cnt_d = '0;
                clk_d = 1'b0;
            end else if (hit) begin
                cnt_d  = '0;
                clk_d  = ~clk_q;
                tick_d = ~clk_q;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end

            // Pending divisor only swaps in at a period boundary.
            if ((restart || hit) && pend_q) begin
                div_d  = pdiv_q;
                pend_d = 1'b0;
            end

            // A load on the swap edge stays pending for the next boundary.
            if (load_i[i]) begin
                pdiv_d = div_i[i*WIDTH +: WIDTH];
                pend_d = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                div_q  <= DEF;
                pdiv_q <= DEF;
                pend_q <= 1'b0;
                cnt_q  <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                div_q  <= div_d;
                pdiv_q <= pdiv_d;
                pend_q <= pend_d;
                cnt_q  <= cnt_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
            end
        end

        assign clk_o[i]  = clk_q;
        assign tick_o[i] = tick_q;
        assign pend_o[i] = pend_q;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Testbench for clk_div_bank: random stimulus, queue scoreboard
// against a countdown-based behavioural model of each channel.
module tb_clk_div_bank;

    localparam int N  = 4;
    localparam int W  = 26;
    localparam int DD = 1;
    localparam int unsigned DMAX = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   en_i = '0;
    logic [N-1:0]   load_i = '0;
    logic [N*W-1:0] div_i = '0;
    logic           sync_i = 1'b0;
    logic [N-1:0]   clk_o;
    logic [N-1:0]   tick_o;
    logic [N-1:0]   pend_o;

    always #5 clk = ~clk;

    clk_div_bank #(
        .NUM_CH      (N),
        .WIDTH       (W),
        .DEFAULT_DIV (DD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
`ifdef CLKDIV_SYNC_EN
        .sync_i (sync_i),
`endif
        .en_i   (en_i),
        .load_i (load_i),
        .div_i  (div_i),
        .clk_o  (clk_o),
        .tick_o (tick_o),
        .pend_o (pend_o)
    );

    int checks = 0;
    int errors = 0;

    logic [3*N-1:0] exp_q[$];

    // Model: each channel counts down the cycles left in its half-period.
    int unsigned m_d[N];
    int unsigned m_p[N];
    int unsigned m_rem[N];
    bit          m_lvl[N];
    bit          m_pend[N];

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_d[c]    = DD;
            m_p[c]    = DD;
            m_rem[c]  = DD;
            m_lvl[c]  = 1'b0;
            m_pend[c] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [N-1:0] en, input logic [N-1:0] ld,
                              input logic [N*W-1:0] dv, input logic sy,
                              output logic [3*N-1:0] ex);
        logic [N-1:0] ec, et, ep;
        for (int c = 0; c < N; c++) begin
            et[c] = 1'b0;
            if (sy || !en[c]) begin
                m_lvl[c] = 1'b0;
                if (m_pend[c]) begin
                    m_d[c]    = m_p[c];
                    m_pend[c] = 1'b0;
                end
                m_rem[c] = m_d[c];
            end else if (m_rem[c] == 0) begin
                m_lvl[c] = !m_lvl[c];
                et[c]    = m_lvl[c];
                if (m_pend[c]) begin
                    m_d[c]    = m_p[c];
                    m_pend[c] = 1'b0;
                end
                m_rem[c] = m_d[c];
            end else begin
                m_rem[c] = m_rem[c] - 1;
            end
            if (ld[c]) begin
                m_p[c]    = int'(dv[c*W +: W]);
                m_pend[c] = 1'b1;
            end
            ec[c] = m_lvl[c];
            ep[c] = m_pend[c];
        end
        ex = {ep, et, ec};
    endtask

    function automatic logic [N*W-1:0] mk(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
        logic [N*W-1:0] v;
        v = {W'(d), W'(c), W'(b), W'(a)};
        return v;
    endfunction

    // Drive one cycle of inputs at the falling edge and queue the response.
    task automatic cycle(input logic [N-1:0] en, input logic [N-1:0] ld,
                         input logic [N*W-1:0] dv, input logic sy);
        logic [3*N-1:0] ex;
        @(negedge clk);
        rst    = 1'b0;
        en_i   = en;
        load_i = ld;
        div_i  = dv;
`ifdef CLKDIV_SYNC_EN
        sync_i = sy;
        model_step(en, ld, dv, sy, ex);
`else
        sync_i = 1'b0;
        model_step(en, ld, dv, 1'b0, ex);
`endif
        exp_q.push_back(ex);
    endtask

    task automatic rand_cycle();
        logic [N-1:0]   en, ld;
        logic [N*W-1:0] dv;
        logic           sy;
        for (int c = 0; c < N; c++) begin
            en[c] = ($urandom_range(0, 7) != 0);
            ld[c] = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 39) == 0)
                dv[c*W +: W] = W'(DMAX);
            else
                dv[c*W +: W] = W'($urandom_range(0, 5));
        end
        sy = ($urandom_range(0, 29) == 0);
        cycle(en, ld, dv, sy);
    endtask

    task automatic chk_zero(input string name);
        checks++;
        if ({pend_o, tick_o, clk_o} !== '0) begin
            errors++;
            $display("FAIL %s: got pend/tick/clk=%h, want 0", name,
                     {pend_o, tick_o, clk_o});
        end
    endtask

    // Monitor: outputs are valid every cycle a response is queued.
    initial begin
        logic [3*N-1:0] ex;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                checks++;
                if ({pend_o, tick_o, clk_o} !== ex) begin
                    errors++;
                    $display("FAIL out t=%0t: got pend/tick/clk=%h, want %h",
                             $time, {pend_o, tick_o, clk_o}, ex);
                end
            end
        end
    end

    initial begin
        int waited;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset_hold");

        // Free run at DEFAULT_DIV: period 4, one tick per period.
        repeat (20) cycle('1, '0, '0, 1'b0);

        // ch0 loads 4 mid-period; ch1 loads 0; ch2 loads 7 then 2.
        cycle('1, 4'b0011, mk(4, 0, 0, 0), 1'b0);
        cycle('1, 4'b0100, mk(0, 0, 7, 0), 1'b0);
        cycle('1, 4'b0100, mk(0, 0, 2, 0), 1'b0);
        repeat (12) cycle('1, '0, '0, 1'b0);
        // ch1 dropped for 3 cycles with D=0.
        repeat (3) cycle(4'b1101, '0, '0, 1'b0);
        repeat (8) cycle('1, '0, '0, 1'b0);

        repeat (400) rand_cycle();

        // Async reset mid-period with every channel at D=9.
        cycle('1, '1, mk(9, 9, 9, 9), 1'b0);
        repeat (25) cycle('1, '0, '0, 1'b0);
        waited = 0;
        while (!(m_lvl[0] || m_lvl[1] || m_lvl[2] || m_lvl[3]) && waited < 40) begin
            cycle('1, '0, '0, 1'b0);
            waited++;
        end
        cycle('1, 4'b0001, mk(3, 0, 0, 0), 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        chk_zero("rst_held");

        // After release the pending 3 is discarded: DEFAULT_DIV everywhere.
        repeat (16) cycle('1, '0, '0, 1'b0);

        repeat (300) rand_cycle();

        @(negedge clk);
        load_i = '0;
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses left, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of independent divider channels (1..16).
REQ-002 The block SHALL have parameter WIDTH, default 26, meaning the width of the divisor and counter per channel.
REQ-003 The block SHALL have parameter DEFAULT_DIV, default 1, meaning the divisor value loaded into every channel at reset.
REQ-004 clk  input  1  sole clock; every register is updated on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en_i  input  NUM_CH  per-channel run enable.
REQ-007 load_i  input  NUM_CH  per-channel divisor-load strobe, sampled on the rising edge of clk.
REQ-008 div_i  input  NUM_CH*WIDTH  new divisor values; channel i uses bits [i*WIDTH +: WIDTH].
REQ-009 clk_o  output  NUM_CH  divided square-wave outputs, registered.
REQ-010 tick_o  output  NUM_CH  one-cycle strobes, high in the cycle in which clk_o[i] is 1 following a 0-to-1 change.
REQ-011 pend_o  output  NUM_CH  high while a loaded divisor is waiting to take effect.

Function
REQ-012 Each channel SHALL hold an active divisor D (WIDTH bits), a counter cnt (WIDTH bits) and an output bit.
REQ-013 With en_i[i]=1, cnt SHALL increment each cycle; when cnt==D, clk_o[i] toggles, cnt returns to 0, and the half-period is therefore D+1 cycles.
REQ-014 D=0 SHALL make clk_o toggle every cycle (clk/2); D=2^WIDTH-1 SHALL be supported with no overflow, because cnt never exceeds D.
REQ-015 tick_o[i] SHALL be asserted for exactly one cycle, aligned with the cycle in which registered clk_o[i] first reads 1, and SHALL never be asserted on a falling toggle.
REQ-016 With en_i[i]=0, cnt SHALL be 0, clk_o[i] SHALL be 0 and tick_o[i] SHALL be 0, all from the next edge.
REQ-017 Deasserting en_i mid-period SHALL abandon the period; on re-enable the first rising toggle SHALL occur D+1 cycles after the first edge that samples en_i=1.
REQ-018 load_i[i]=1 SHALL capture div_i slice i into a pending register and set pend_o[i] on the next edge.
REQ-019 A pending divisor SHALL become active D only at a toggle edge (cnt==D), or at the next edge if en_i[i]=0, and pend_o[i] SHALL clear on that same edge.
REQ-020 A load while pend_o[i]=1 SHALL overwrite the pending value; only the last value loaded SHALL take effect.
REQ-021 If load_i[i] coincides with a toggle edge, the toggle SHALL use the old D, and the new value SHALL become pending, not active.
REQ-022 Channels SHALL be fully independent; activity on one channel SHALL NOT alter the timing of any other channel.
REQ-023 No output SHALL be driven combinationally from an input.

Reset
REQ-024 While rst=1, every channel SHALL have D=DEFAULT_DIV, cnt=0, pending register=DEFAULT_DIV, clk_o=0, tick_o=0 and pend_o=0, regardless of clk.
REQ-025 Reset asserted mid-period SHALL take effect immediately, without waiting for a clk edge, and SHALL discard any pending load.
REQ-026 After rst falls, a channel with en_i=1 SHALL produce its first rising clk_o DEFAULT_DIV+1 cycles later.

Configuration
REQ-027 Macro CLKDIV_SYNC_EN, when defined, SHALL add input sync_i (1 bit); sync_i=1 SHALL force every channel to cnt=0 and clk_o=0, apply any pending divisor and clear pend_o, so that all enabled channels restart phase-aligned.
REQ-028 When sync_i=1 and load_i are asserted on the same edge, the load SHALL become pending after the sync.
REQ-029 Without CLKDIV_SYNC_EN, the sync_i port SHALL be absent and there SHALL be no phase-realignment path apart from en_i and rst.

Verification
REQ-030 NUM_CH=4, DEFAULT_DIV=1, all en_i=1 after reset -> each clk_o has period 4 cycles, 50% duty; one tick_o pulse every 4 cycles.
REQ-031 Channel 0 enabled; load_i[0] with div=4 mid-period -> pend_o[0] high until the next toggle, then half-period 5 cycles; the current half-period is unchanged.
REQ-032 Channel 1 running with D=0; en_i[1] dropped for 3 cycles -> clk_o[1]=0, tick_o[1]=0; on re-enable, first rising edge after 1 cycle, then toggles every cycle.
REQ-033 Two loads on channel 2 (div=7, then div=2) before its toggle -> only D=2 is applied; pend_o[2] stays high throughout and clears at the toggle.
REQ-034 rst pulsed asynchronously between clk edges while channels run with D=9 -> outputs go to 0 immediately; after release, D=DEFAULT_DIV=1 on all channels.
REQ-035 With CLKDIV_SYNC_EN defined, channels running with D=1, 2, 3 and 5 and sync_i pulsed -> all clk_o drop to 0 and rise together at their respective D+1 cycles after the sync edge.
